// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 serial receiver with a valid/ready byte output.
// Two-flop input synchronizer, mid-bit sampling FSM, framing-error pulse
// and sticky overrun flag. Only good bytes are ever presented as valid.
`timescale 1ns/1ps
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_reg;
    logic            sync_0;
    logic            rxs;

    // Bring the asynchronous serial line into the clock domain; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_0 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            sync_0 <= rx_in;
            rxs    <= sync_0;
        end
    end

    // Frame recovery FSM with the output handshake, error flags and busy all registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= 1'b0;

            // An accepted byte retires here; a byte loaded below in the same cycle wins.
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end

                START: begin
                    if (bit_cnt == HALF_LAST) begin
                        bit_cnt <= '0;
                        if (!rxs) begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt   <= '0;
                        shift_reg <= {rxs, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            state     <= BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end

                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
